// File: rtl/serial_signed_comparator_if.sv
// Handshake bundle for serial_signed_comparator: operand side, result side, and
// the completed-result counter.
`timescale 1ns/1ps
interface serial_signed_comparator_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic             agtb;
    logic             aeqb;
    logic             altb;
    logic             signa;
    logic             signb;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, agtb, aeqb, altb, signa, signb, count
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, agtb, aeqb, altb, signa, signb, count
    );
endinterface

// File: rtl/serial_signed_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or
// unsigned, with valid/ready on both sides and a completed-result counter.
`timescale 1ns/1ps
module serial_signed_comparator #(
    parameter int WIDTH      = 4,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 0,
    parameter int CNT_W      = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    serial_signed_comparator_if.slave bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {DEC_UND, DEC_GT, DEC_LT} dec_t;

    state_t           state;
    dec_t             dec, dec_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-1:0] msb_flip;
    logic [DIGIT-1:0] top_a, top_b;
    logic [IDX_W-1:0] dig_cnt;
    logic             last_dig, finish;

    logic             in_ready_q, out_valid_q;
    logic             agtb_q, aeqb_q, altb_q, signa_q, signb_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        // Flipping both sign bits maps two's complement order onto unsigned order.
        msb_flip = {bus.mode, {(WIDTH-1){1'b0}}};
        top_a    = sh_a[WIDTH-1 -: DIGIT];
        top_b    = sh_b[WIDTH-1 -: DIGIT];
        dec_nxt  = dec;
        if (dec == DEC_UND) begin
            if (top_a > top_b)      dec_nxt = DEC_GT;
            else if (top_a < top_b) dec_nxt = DEC_LT;
        end
        last_dig = (dig_cnt == IDX_W'(NDIG - 1));
        finish   = last_dig || ((EARLY_EXIT != 0) && (dec_nxt != DEC_UND));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dec         <= DEC_UND;
            sh_a        <= '0;
            sh_b        <= '0;
            dig_cnt     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            agtb_q      <= 1'b0;
            aeqb_q      <= 1'b0;
            altb_q      <= 1'b0;
            signa_q     <= 1'b0;
            signb_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        sh_a       <= bus.a ^ msb_flip;
                        sh_b       <= bus.b ^ msb_flip;
                        dig_cnt    <= '0;
                        dec        <= DEC_UND;
                        signa_q    <= bus.mode & bus.a[WIDTH-1];
                        signb_q    <= bus.mode & bus.b[WIDTH-1];
                    end
                end
                RUN: begin
                    sh_a    <= sh_a << DIGIT;
                    sh_b    <= sh_b << DIGIT;
                    dec     <= dec_nxt;
                    dig_cnt <= dig_cnt + IDX_W'(1);
                    if (finish) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        agtb_q      <= (dec_nxt == DEC_GT);
                        altb_q      <= (dec_nxt == DEC_LT);
                        aeqb_q      <= (dec_nxt == DEC_UND);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        count_q     <= count_q + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.agtb      = agtb_q;
    assign bus.aeqb      = aeqb_q;
    assign bus.altb      = altb_q;
    assign bus.signa     = signa_q;
    assign bus.signb     = signb_q;
    assign bus.count     = count_q;
endmodule
